uart_mmio: RTL and testbench

Memory-mapped UART front end for the RISC-V core: a CPU-side register port with an 8-bit TX FIFO and an 8-bit RX FIFO, sitting between the core's MMIO decode and the `uart` block. TX bytes written by the core are buffered and drained into the UART transmitter over ready/valid. Received bytes are captured from the UART receiver into the RX FIFO for polling. FIFO occupancy and sticky overflow flags are exposed in a status register.

---
 rtl/uart_mmio.sv | 107 ++++++++++
 tb/tb_uart_mmio.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_mmio: CPU register port with TX/RX byte FIFOs in front of the UART. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module uart_mmio #(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  addr,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_RX_DATA = 2'd1;
  localparam logic [1:0] REG_TX_DATA = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          tx_ovf, rx_ovf;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_wr, tx_push, tx_pop, rx_push, rx_pop, ctl_wr;
  logic [31:0] status;
  logic unused_bits;

  assign unused_bits = &{1'b0, addr[1:0], wdata[31:8]};

  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);

  assign uart_tx_valid = !tx_empty;
  assign uart_tx_data  = tx_mem[tx_rp];
  assign uart_rx_ready = !reset;

  // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
  assign tx_wr   = wr_en && (addr[3:2] == REG_TX_DATA);
  assign tx_pop  = uart_tx_valid && uart_tx_ready;
  assign tx_push = tx_wr && (!tx_full || tx_pop);
  assign rx_pop  = rd_en && (addr[3:2] == REG_RX_DATA) && !rx_empty;
  assign rx_push = uart_rx_valid && (!rx_full || rx_pop);
  assign ctl_wr  = wr_en && (addr[3:2] == REG_CONTROL);

  assign status = {8'd0, 8'(rx_cnt), 8'(tx_cnt), 4'd0, tx_ovf, rx_ovf, !rx_empty, !tx_full};

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
      rdata  <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CW'(1);
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CW'(1);

      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CW'(1);
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CW'(1);

      // Setting a flag wins over a CONTROL clear on the same edge.
      if (tx_wr && !tx_push)            tx_ovf <= 1'b1;
      else if (ctl_wr && wdata[1])      tx_ovf <= 1'b0;
      if (uart_rx_valid && !rx_push)    rx_ovf <= 1'b1;
      else if (ctl_wr && wdata[0])      rx_ovf <= 1'b0;

      if (rd_en) begin
        case (addr[3:2])
          REG_STATUS:  rdata <= status;
          REG_RX_DATA: rdata <= rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp]};
          default:     rdata <= 32'd0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_mmio: directed and random stimulus against a queue-based model.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_uart_mmio;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  addr = '0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;

  int vectors = 0;
  int miscompares = 0;

  byte unsigned txq[$];
  byte unsigned rxq[$];
  bit           tx_ovf_m, rx_ovf_m;
  logic [31:0]  rdata_m;

  uart_mmio #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wdata(wdata),
    .rd_en(rd_en), .rdata(rdata), .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_m();
    return {8'd0, 8'(rxq.size()), 8'(txq.size()), 4'd0, tx_ovf_m, rx_ovf_m,
            rxq.size() != 0, txq.size() < DEPTH};
  endfunction

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    tx_ovf_m = 1'b0;
    rx_ovf_m = 1'b0;
    rdata_m  = '0;
  endtask

  // One clock: predict from pre-edge state, advance, then compare.
  task automatic tick();
    bit txpop, rxpop, txw, txacc, rxacc;
    logic [1:0]  a;
    logic [31:0] nrd;
    byte unsigned wbyte, rbyte;
    a     = addr[3:2];
    wbyte = wdata[7:0];
    rbyte = uart_rx_data;
    txpop = (txq.size() != 0) && uart_tx_ready;
    rxpop = rd_en && (a == 2'd1) && (rxq.size() != 0);
    txw   = wr_en && (a == 2'd2);
    txacc = txw && ((txq.size() < DEPTH) || txpop);
    rxacc = uart_rx_valid && ((rxq.size() < DEPTH) || rxpop);
    nrd   = rdata_m;
    if (rd_en) begin
      if (a == 2'd0) nrd = status_m();
      else if (a == 2'd1) nrd = (rxq.size() != 0) ? {24'd0, rxq[0]} : 32'd0;
      else nrd = 32'd0;
    end
    if (wr_en && a == 2'd3) begin
      if (wdata[0]) rx_ovf_m = 1'b0;
      if (wdata[1]) tx_ovf_m = 1'b0;
    end
    if (txw && !txacc) tx_ovf_m = 1'b1;
    if (uart_rx_valid && !rxacc) rx_ovf_m = 1'b1;
    @(posedge clk);
    #1;
    if (txpop) void'(txq.pop_front());
    if (txacc) txq.push_back(wbyte);
    if (rxpop) void'(rxq.pop_front());
    if (rxacc) rxq.push_back(rbyte);
    rdata_m = nrd;
    chk("rdata", rdata, rdata_m);
    chk("tx_valid", 32'(uart_tx_valid), 32'(txq.size() != 0));
    if (txq.size() != 0) chk("tx_data", 32'(uart_tx_data), 32'(txq[0]));
    chk("rx_ready", 32'(uart_rx_ready), 32'd1);
    wr_en = 1'b0;
    rd_en = 1'b0;
    uart_rx_valid = 1'b0;
  endtask

  task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
  endtask

  task automatic reg_rd(input logic [3:0] a);
    addr = a; rd_en = 1'b1;
    tick();
  endtask

  task automatic rx_byte(input logic [7:0] d);
    uart_rx_data = d; uart_rx_valid = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] seq [3];
    seq[0] = 8'h41; seq[1] = 8'h42; seq[2] = 8'h43;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_tx_valid", 32'(uart_tx_valid), 32'd0);
    chk("reset_rx_ready", 32'(uart_rx_ready), 32'd0);
    reset = 1'b0;

    // Reset state through STATUS.
    reg_rd(4'h0);
    chk("status_after_reset", rdata, 32'h0000_0001);

    // Three TX bytes held, then drained in order.
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) reg_wr(4'h8, {24'd0, seq[i]});
    reg_rd(4'h0);
    chk("tx_count3", 32'(rdata[15:8]), 32'd3);
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("tx_drain_byte", 32'(uart_tx_data), 32'(seq[i]));
      tick();
    end
    chk("tx_valid_drop", 32'(uart_tx_valid), 32'd0);

    // TX overflow and clear.
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) reg_wr(4'h8, 32'(8'h60 + i));
    reg_rd(4'h0);
    chk("tx_full_ovf", rdata, 32'h0000_0808);
    reg_wr(4'hC, 32'h2);
    reg_rd(4'h0);
    chk("tx_ovf_clear", rdata, 32'h0000_0800);
    uart_tx_ready = 1'b1;
    repeat (8) tick();
    uart_tx_ready = 1'b0;

    // RX fill, overflow, drain, empty read.
    for (int i = 0; i < 8; i++) rx_byte(8'h10 + 8'(i));
    reg_rd(4'h0);
    chk("rx_full", rdata, 32'h0008_0003);
    rx_byte(8'h55);
    reg_rd(4'h0);
    chk("rx_ovf", rdata, 32'h0008_0007);
    for (int i = 0; i < 8; i++) begin
      reg_rd(4'h4);
      chk("rx_read", rdata, 32'h10 + 32'(i));
    end
    reg_rd(4'h4);
    chk("rx_empty_read", rdata, 32'd0);
    reg_rd(4'h0);
    chk("rx_empty_status", rdata, 32'h0000_0005);
    reg_wr(4'hC, 32'h1);

    // Full RX with coincident pop and push.
    for (int i = 0; i < 8; i++) rx_byte(8'h20 + 8'(i));
    uart_rx_data = 8'h99; uart_rx_valid = 1'b1;
    reg_rd(4'h4);
    chk("rx_pop_push", rdata, 32'h20);
    reg_rd(4'h0);
    chk("rx_no_ovf", rdata, 32'h0008_0003);
    for (int i = 0; i < 7; i++) reg_rd(4'h4);
    reg_rd(4'h4);
    chk("rx_last_99", rdata, 32'h99);

    // Wrap-around with simultaneous push/pop.
    for (int i = 0; i < 20; i++) begin
      uart_rx_data = 8'($urandom); uart_rx_valid = 1'b1;
      reg_rd(4'h4);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      addr          = 4'($urandom);
      rd_en         = 1'($urandom);
      wr_en         = ($urandom % 3) == 0;
      wdata         = $urandom;
      uart_tx_ready = ($urandom % 4) == 0;
      uart_rx_valid = 1'($urandom);
      uart_rx_data  = 8'($urandom);
      tick();
    end

    // Asynchronous reset during a TX drain.
    reg_wr(4'hC, 32'h3);
    uart_tx_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) reg_wr(4'h8, 32'(8'hA0 + i));
    uart_tx_ready = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("midreset_tx_valid", 32'(uart_tx_valid), 32'd0);
    chk("midreset_rdata", rdata, 32'd0);
    chk("midreset_rx_ready", 32'(uart_rx_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    uart_tx_ready = 1'b0;
    reg_rd(4'h0);
    chk("status_after_midreset", rdata, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
